alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
Parametrised, registered ALU with a START/BUSY/DONE handshake. It is the next generation of the datapath ALU.
- Single-cycle ops (add, sub, shifts, logic, slt) return a result one cycle after START.
- Signed multiply runs iteratively and returns a full double-width product.
- Sits between the register file read stage and the writeback mux; the control unit stalls on BUSY.

Parameters:
DATA_WIDTH, 32, operand/result width; power of two, >= 8.
OPRN_WIDTH, 6, opcode width.
SHAMT_WIDTH, 5, log2(DATA_WIDTH); shift-amount field width.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  reset; asynchronous assert, active-low.
START  input  1  request; sampled only while BUSY=0.
OPRN  input  OPRN_WIDTH  opcode, captured with START.
OP1  input  DATA_WIDTH  operand 1, captured with START.
OP2  input  DATA_WIDTH  operand 2, captured with START.
OUT  output  DATA_WIDTH  result, or low half of product.
OUT_HI  output  DATA_WIDTH  high half of product; 0 for all other ops.
ZERO  output  1  registered; 1 when the OUT value just written is all zeros.
BUSY  output  1  iterative op in progress.
DONE  output  1  one-cycle pulse; OUT/OUT_HI/ZERO valid from this cycle.

Behaviour:
- Reset (RST=0): OUT=0, OUT_HI=0, ZERO=1, BUSY=0, DONE=0, state=IDLE, counter=0. Reset mid-operation aborts; no DONE is produced.
- Opcodes:
  - 0x1 add, 0x2 sub: modulo 2^DATA_WIDTH.
  - 0x3 signed mul: two's complement, 2*DATA_WIDTH-bit product.
  - 0x4 logical shift right, 0x5 shift left: OP1 shifted by OP2. If OP2 >= DATA_WIDTH (any bit above SHAMT_WIDTH-1 set), result is 0.
  - 0x6 and, 0x7 or, 0x8 nor.
  - 0x9 slt: OUT=1 if signed OP1 < signed OP2, else 0. Overflow-correct; not just the sign of the difference.
  - All other codes: OUT=0, OUT_HI=0, single-cycle.
- State IDLE (BUSY=0):
  - START=1 with a single-cycle opcode: result registered at that edge; DONE=1 the next cycle; stay IDLE. Back-to-back START every cycle gives one result per cycle.
  - START=1 with mul: latch operand magnitudes and product sign; counter=0; BUSY=1; go RUN.
- State RUN (BUSY=1):
  - One shift-add step per cycle; counter increments.
  - START is ignored; OP1/OP2/OPRN are don't-care.
  - After DATA_WIDTH steps (counter reaches DATA_WIDTH-1): apply sign correction, write {OUT_HI,OUT}, DONE=1, BUSY=0, return to IDLE.
  - START accepted again in the DONE cycle.
- Latency, START edge to DONE high:
  - Single-cycle ops: 1 cycle.
  - mul: DATA_WIDTH cycles (32 at default).
- Outputs hold their last result until the next DONE; they never change while BUSY.
- ZERO is updated together with OUT, covering only OUT.
- DONE never asserts without a preceding accepted START.

Optional Feature:
Macro ALU_DIV_EN.
- Defined: opcode 0xA is signed divide.
  - Restoring division, DATA_WIDTH iterations through RUN; same latency as mul.
  - OUT = quotient, truncated toward zero; OUT_HI = remainder, with the sign of the dividend.
  - Divide by zero: OUT = all ones, OUT_HI = OP1, same latency.
  - Most-negative / -1: OUT = most-negative, OUT_HI = 0.
- Undefined: 0xA is an invalid opcode (single-cycle, OUT=0, OUT_HI=0); no divider logic is synthesised.

Test Plan:
- Reset then idle: RST low mid-cycle -> OUT=0, OUT_HI=0, ZERO=1, BUSY=0, DONE=0 immediately (asynchronous); no DONE after release.
- Back-to-back single-cycle ops: add 0x7FFFFFFF+1, sub 5-5, slt 0x80000000 vs 1, sll 1 by 32 on consecutive cycles -> DONE every cycle, with:
  - OUT=0x80000000, ZERO=0
  - OUT=0, ZERO=1
  - OUT=1
  - OUT=0
- Signed mul: -3 x 7 -> BUSY for 32 cycles, DONE on cycle 32, OUT=0xFFFFFFEB, OUT_HI=0xFFFFFFFF. Also 0xFFFFFFFF x 0xFFFFFFFF -> OUT=1, OUT_HI=0.
- START while busy: pulse START (add 1+1) 5 cycles into a mul -> ignored; only the mul result is delivered. START held during the DONE cycle -> the add is accepted and DONE follows 1 cycle later with OUT=2.
- Reset mid-mul: RST low at cycle 10 of mul -> BUSY=0, OUT=0 immediately; no DONE; a new add after release completes normally.
- ALU_DIV_EN: -7 / 2 -> OUT=0xFFFFFFFD, OUT_HI=0xFFFFFFFF after 32 cycles. 9 / 0 -> OUT=0xFFFFFFFF, OUT_HI=9. Without the macro, 0xA -> OUT=0 after 1 cycle.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle for alu_multicycle.
// The master drives the request side; the slave (the ALU) drives the results.
interface alu_multicycle_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
);
  logic                  START;
  logic [OPRN_WIDTH-1:0] OPRN;
  logic [DATA_WIDTH-1:0] OP1;
  logic [DATA_WIDTH-1:0] OP2;
  logic [DATA_WIDTH-1:0] OUT;
  logic [DATA_WIDTH-1:0] OUT_HI;
  logic                  ZERO;
  logic                  BUSY;
  logic                  DONE;

  modport master (
    output START, OPRN, OP1, OP2,
    input  OUT, OUT_HI, ZERO, BUSY, DONE
  );

  modport slave (
    input  START, OPRN, OP1, OP2,
    output OUT, OUT_HI, ZERO, BUSY, DONE
  );
endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU with START/BUSY/DONE handshake and iterative signed multiply.
// Define ALU_DIV_EN to add iterative signed divide on opcode 0xA.
module alu_multicycle #(
  parameter int DATA_WIDTH  = 32,
  parameter int OPRN_WIDTH  = 6,
  parameter int SHAMT_WIDTH = 5
) (
  input logic             CLK,
  input logic             RST,
  alu_multicycle_if.slave bus
);
  localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
  localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
  localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
  localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(4);
  localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(5);
  localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
  localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
  localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
  localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);
`ifdef ALU_DIV_EN
  localparam logic [OPRN_WIDTH-1:0] OP_DIV = OPRN_WIDTH'(10);
`endif
  // The first iteration happens on the START edge, so RUN covers the remaining DATA_WIDTH-1.
  localparam logic [SHAMT_WIDTH-1:0] LAST_STEP = SHAMT_WIDTH'(DATA_WIDTH - 2);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // {high accumulator, multiplier}: add multiplicand on LSB, then shift right.
  function automatic logic [2*DATA_WIDTH-1:0] mul_step(
    input logic [2*DATA_WIDTH-1:0] p,
    input logic [DATA_WIDTH-1:0]   m
  );
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, p[2*DATA_WIDTH-1:DATA_WIDTH]} + (p[0] ? {1'b0, m} : {(DATA_WIDTH+1){1'b0}});
    return {sum, p[DATA_WIDTH-1:1]};
  endfunction

`ifdef ALU_DIV_EN
  // {remainder, dividend/quotient}: shift one dividend bit in, subtract divisor if it fits.
  function automatic logic [2*DATA_WIDTH-1:0] div_step(
    input logic [2*DATA_WIDTH-1:0] p,
    input logic [DATA_WIDTH-1:0]   d
  );
    logic [DATA_WIDTH:0] r_sh;
    r_sh = {p[2*DATA_WIDTH-1:DATA_WIDTH], p[DATA_WIDTH-1]};
    if (r_sh < {1'b0, d}) begin
      return {r_sh[DATA_WIDTH-1:0], p[DATA_WIDTH-2:0], 1'b0};
    end else begin
      return {r_sh[DATA_WIDTH-1:0] - d, p[DATA_WIDTH-2:0], 1'b1};
    end
  endfunction
`endif

  state_t                   state_r;
  logic [SHAMT_WIDTH-1:0]   counter_r;
  logic [2*DATA_WIDTH-1:0]  p_r;
  logic [DATA_WIDTH-1:0]    m_r;
  logic                     neg_r;
  logic [DATA_WIDTH-1:0]    out_r;
  logic [DATA_WIDTH-1:0]    out_hi_r;
  logic                     zero_r;
  logic                     busy_r;
  logic                     done_r;
`ifdef ALU_DIV_EN
  logic                     is_div_r;
  logic                     rem_neg_r;
  logic                     div_zero_r;
  logic                     div_req_s;
  logic [DATA_WIDTH-1:0]    quo_s;
  logic [DATA_WIDTH-1:0]    rem_s;
`endif

  logic [DATA_WIDTH-1:0]    alu_res_s;
  logic                     shamt_ovf_s;
  logic                     op1_neg_s;
  logic                     op2_neg_s;
  logic [DATA_WIDTH-1:0]    op1_mag_s;
  logic [DATA_WIDTH-1:0]    op2_mag_s;
  logic                     iter_req_s;
  logic [2*DATA_WIDTH-1:0]  init_p_s;
  logic [DATA_WIDTH-1:0]    init_m_s;
  logic [2*DATA_WIDTH-1:0]  next_p_s;
  logic [2*DATA_WIDTH-1:0]  mul_prod_s;
  logic [DATA_WIDTH-1:0]    fin_lo_s;
  logic [DATA_WIDTH-1:0]    fin_hi_s;

  // Single-cycle result from the live operands.
  always_comb begin
    shamt_ovf_s = |bus.OP2[DATA_WIDTH-1:SHAMT_WIDTH];
    alu_res_s   = '0;
    case (bus.OPRN)
      OP_ADD:  alu_res_s = bus.OP1 + bus.OP2;
      OP_SUB:  alu_res_s = bus.OP1 - bus.OP2;
      OP_SRL:  alu_res_s = shamt_ovf_s ? '0 : (bus.OP1 >> bus.OP2[SHAMT_WIDTH-1:0]);
      OP_SLL:  alu_res_s = shamt_ovf_s ? '0 : (bus.OP1 << bus.OP2[SHAMT_WIDTH-1:0]);
      OP_AND:  alu_res_s = bus.OP1 & bus.OP2;
      OP_OR:   alu_res_s = bus.OP1 | bus.OP2;
      OP_NOR:  alu_res_s = ~(bus.OP1 | bus.OP2);
      OP_SLT:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.OP1) < $signed(bus.OP2))};
      default: alu_res_s = '0;
    endcase
  end

  // Iterative-op setup: magnitudes, first step and sign bookkeeping.
  always_comb begin
    op1_neg_s  = bus.OP1[DATA_WIDTH-1];
    op2_neg_s  = bus.OP2[DATA_WIDTH-1];
    op1_mag_s  = op1_neg_s ? -bus.OP1 : bus.OP1;
    op2_mag_s  = op2_neg_s ? -bus.OP2 : bus.OP2;
    iter_req_s = (bus.OPRN == OP_MUL);
    init_m_s   = op1_mag_s;
    init_p_s   = mul_step({{DATA_WIDTH{1'b0}}, op2_mag_s}, op1_mag_s);
`ifdef ALU_DIV_EN
    div_req_s  = (bus.OPRN == OP_DIV);
    if (div_req_s) begin
      iter_req_s = 1'b1;
      init_m_s   = op2_mag_s;
      init_p_s   = div_step({{DATA_WIDTH{1'b0}}, op1_mag_s}, op2_mag_s);
    end else begin
      iter_req_s = (bus.OPRN == OP_MUL);
    end
`endif
  end

  // RUN-state step and final sign-corrected results.
  always_comb begin
    next_p_s   = mul_step(p_r, m_r);
    mul_prod_s = neg_r ? -next_p_s : next_p_s;
    fin_lo_s   = mul_prod_s[DATA_WIDTH-1:0];
    fin_hi_s   = mul_prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef ALU_DIV_EN
    quo_s = '0;
    rem_s = '0;
    if (is_div_r) begin
      next_p_s = div_step(p_r, m_r);
      quo_s    = next_p_s[DATA_WIDTH-1:0];
      rem_s    = next_p_s[2*DATA_WIDTH-1:DATA_WIDTH];
      // Divide by zero leaves |OP1| in the remainder, so the dividend sign restores OP1.
      fin_lo_s = div_zero_r ? '1 : (neg_r ? -quo_s : quo_s);
      fin_hi_s = rem_neg_r ? -rem_s : rem_s;
    end else begin
      quo_s = '0;
      rem_s = '0;
    end
`endif
  end

  // Control FSM with registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= IDLE;
      counter_r  <= '0;
      p_r        <= '0;
      m_r        <= '0;
      neg_r      <= 1'b0;
      out_r      <= '0;
      out_hi_r   <= '0;
      zero_r     <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef ALU_DIV_EN
      is_div_r   <= 1'b0;
      rem_neg_r  <= 1'b0;
      div_zero_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.START) begin
            if (iter_req_s) begin
              state_r   <= RUN;
              busy_r    <= 1'b1;
              counter_r <= '0;
              p_r       <= init_p_s;
              m_r       <= init_m_s;
              neg_r     <= op1_neg_s ^ op2_neg_s;
`ifdef ALU_DIV_EN
              is_div_r   <= div_req_s;
              rem_neg_r  <= op1_neg_s;
              div_zero_r <= (bus.OP2 == '0);
`endif
            end else begin
              out_r    <= alu_res_s;
              out_hi_r <= '0;
              zero_r   <= (alu_res_s == '0);
              done_r   <= 1'b1;
            end
          end
        end
        RUN: begin
          counter_r <= counter_r + SHAMT_WIDTH'(1);
          p_r       <= next_p_s;
          if (counter_r == LAST_STEP) begin
            out_r    <= fin_lo_s;
            out_hi_r <= fin_hi_s;
            zero_r   <= (fin_lo_s == '0);
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.OUT    = out_r;
  assign bus.OUT_HI = out_hi_r;
  assign bus.ZERO   = zero_r;
  assign bus.BUSY   = busy_r;
  assign bus.DONE   = done_r;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed, table-driven bench for alu_multicycle (default 32-bit build).
module tb_alu_multicycle;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  alu_multicycle_if #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) bus ();

  alu_multicycle #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .SHAMT_WIDTH(5)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic start, input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b);
    bus.START = start;
    bus.OPRN  = opc;
    bus.OP1   = a;
    bus.OP2   = b;
  endtask

  // Issue one iterative op and follow it to DONE, checking latency, BUSY and output hold.
  task automatic run_iter(input string name, input logic [5:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] prev_out, input logic [63:0] exp);
    int   n;
    logic hold_ok;
    set_req(1'b1, opc, a, b);
    @(posedge clk); #1;
    set_req(1'b0, 6'h01, 32'hDEAD_BEEF, 32'h1234_5678);
    n = 1;
    hold_ok = 1'b1;
    while (bus.DONE !== 1'b1 && n < 100) begin
      if (bus.BUSY !== 1'b1 || bus.OUT !== prev_out) hold_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, 64'(n), 64'd32);
    check({name, " busy+hold"}, {63'd0, hold_ok}, 64'd1);
    check({name, " busy at done"}, {63'd0, bus.BUSY}, 64'd0);
    check({name, " product"}, {bus.OUT_HI, bus.OUT}, exp);
    check({name, " zero"}, {63'd0, bus.ZERO}, {63'd0, (exp[31:0] == 32'd0)});
    @(posedge clk); #1;
    check({name, " done pulse"}, {63'd0, bus.DONE}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen;
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    set_req(1'b0, 6'h00, 32'd0, 32'd0);

    vecs[0]  = '{"add ovf",   6'h01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[1]  = '{"sub 5-5",   6'h02, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
    vecs[2]  = '{"slt min<1", 6'h09, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[3]  = '{"sll by 32", 6'h05, 32'h0000_0001, 32'h0000_0020, 32'h0000_0000, 1'b1};
    vecs[4]  = '{"srl by 4",  6'h04, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0};
    vecs[5]  = '{"sll by 31", 6'h05, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0};
    vecs[6]  = '{"srl 0x100", 6'h04, 32'h0000_000F, 32'h0000_0100, 32'h0000_0000, 1'b1};
    vecs[7]  = '{"and",       6'h06, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0};
    vecs[8]  = '{"or",        6'h07, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0};
    vecs[9]  = '{"nor",       6'h08, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{"slt ovf",   6'h09, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{"slt -1<0",  6'h09, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[12] = '{"bad 3f",    6'h3F, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[13] = '{"add wrap",  6'h01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[14] = '{"sub 0-1",   6'h02, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[15] = '{"op 00",     6'h00, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1};
    vecs[16] = '{"srl 31",    6'h04, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, 1'b0};

    // Asynchronous reset mid-cycle, then idle with no spurious DONE.
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst out",    {32'd0, bus.OUT},    64'd0);
    check("rst out_hi", {32'd0, bus.OUT_HI}, 64'd0);
    check("rst zero",   {63'd0, bus.ZERO},   64'd1);
    check("rst busy",   {63'd0, bus.BUSY},   64'd0);
    check("rst done",   {63'd0, bus.DONE},   64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.DONE !== 1'b0) seen = 1'b1;
    end
    check("idle no done", {63'd0, seen}, 64'd0);

    // Back-to-back single-cycle ops: one result per cycle.
    foreach (vecs[i]) begin
      set_req(1'b1, vecs[i].opc, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      check({vecs[i].name, " done"},   {63'd0, bus.DONE},   64'd1);
      check({vecs[i].name, " out"},    {32'd0, bus.OUT},    {32'd0, vecs[i].exp_out});
      check({vecs[i].name, " out_hi"}, {32'd0, bus.OUT_HI}, 64'd0);
      check({vecs[i].name, " zero"},   {63'd0, bus.ZERO},   {63'd0, vecs[i].exp_zero});
    end
    set_req(1'b0, 6'h00, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("b2b done drops", {63'd0, bus.DONE}, 64'd0);

    // Signed multiply corners.
    run_iter("mul -3x7",  6'h03, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFEB);
    run_iter("mul -1x-1", 6'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 64'h0000_0000_0000_0001);
    run_iter("mul minxmin", 6'h03, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 64'h4000_0000_0000_0000);
    run_iter("mul minx1", 6'h03, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 64'hFFFF_FFFF_8000_0000);

    // A following single-cycle op clears OUT_HI.
    set_req(1'b1, 6'h01, 32'd2, 32'd3);
    @(posedge clk); #1;
    set_req(1'b0, 6'h00, 32'd0, 32'd0);
    check("add after mul out",    {32'd0, bus.OUT},    64'd5);
    check("add after mul out_hi", {32'd0, bus.OUT_HI}, 64'd0);

    // START ignored while busy; held START accepted in the DONE cycle.
    set_req(1'b1, 6'h03, 32'd5, 32'd6);
    @(posedge clk); #1;
    set_req(1'b0, 6'h00, 32'd0, 32'd0);
    n = 1;
    repeat (4) begin @(posedge clk); #1; n++; end
    set_req(1'b1, 6'h01, 32'd1, 32'd1);
    seen = 1'b0;
    while (bus.DONE !== 1'b1 && n < 100) begin
      if (bus.BUSY !== 1'b1) seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("busy start latency", 64'(n), 64'd32);
    check("busy start ignored", {63'd0, seen}, 64'd0);
    check("busy start mul out", {bus.OUT_HI, bus.OUT}, 64'd30);
    @(posedge clk); #1;
    set_req(1'b0, 6'h00, 32'd0, 32'd0);
    check("done-cycle start done", {63'd0, bus.DONE}, 64'd1);
    check("done-cycle start out",  {32'd0, bus.OUT},  64'd2);
    @(posedge clk); #1;
    check("done-cycle start once", {63'd0, bus.DONE}, 64'd0);

    // Reset during a multiply aborts it.
    set_req(1'b1, 6'h03, 32'd3, 32'd4);
    @(posedge clk); #1;
    set_req(1'b0, 6'h00, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid rst busy",   {63'd0, bus.BUSY},   64'd0);
    check("mid rst out",    {32'd0, bus.OUT},    64'd0);
    check("mid rst out_hi", {32'd0, bus.OUT_HI}, 64'd0);
    check("mid rst zero",   {63'd0, bus.ZERO},   64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) seen = 1'b1;
    end
    check("mid rst no done", {63'd0, seen}, 64'd0);
    set_req(1'b1, 6'h01, 32'd3, 32'd4);
    @(posedge clk); #1;
    set_req(1'b0, 6'h00, 32'd0, 32'd0);
    check("post rst add done", {63'd0, bus.DONE}, 64'd1);
    check("post rst add out",  {32'd0, bus.OUT},  64'd7);

`ifdef ALU_DIV_EN
    run_iter("div -7/2",   6'h0A, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFFD);
    run_iter("div 9/0",    6'h0A, 32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFD, 64'h0000_0009_FFFF_FFFF);
    run_iter("div min/-1", 6'h0A, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
`else
    set_req(1'b1, 6'h0A, 32'h0000_0009, 32'h0000_0002);
    @(posedge clk); #1;
    set_req(1'b0, 6'h00, 32'd0, 32'd0);
    check("op 0a done", {63'd0, bus.DONE},      64'd1);
    check("op 0a out",  {bus.OUT_HI, bus.OUT},  64'd0);
    check("op 0a busy", {63'd0, bus.BUSY},      64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
